// File: rtl/sram_rd_stream.sv
// Streams a contiguous SRAM address range out of the macro read port
// into a credit-protected FWFT FIFO with a valid/ready interface.
module sram_rd_stream #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 11,
    parameter int DEPTH      = 1296,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CE,
    input  logic              RSTB,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] A1,
    output logic              CSB1,
    output logic              OEB1,
    input  logic [DATA_W-1:0] O1,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] a1_q, a1_d;
    logic [LEN_W-1:0] iss_rem_q, iss_rem_d;
    logic [LEN_W-1:0] pop_rem_q, pop_rem_d;
    logic csb_q, csb_d;
    logic done_q, done_d;
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic push, pop, credit;
    logic [CNT_W:0] occ;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        a1_d      = a1_q;
        iss_rem_d = iss_rem_q;
        pop_rem_d = pop_rem_q;
        csb_d     = 1'b1;
        done_d    = 1'b0;
        v1_d      = 1'b0;
        v2_d      = v1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        push = v2_q;
        pop  = (cnt_q != '0) && M_READY;
        // Credit counts reads still in the macro pipeline, not just stored words
        occ = {1'b0, cnt_q} + {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q};
        credit = occ < {1'b0, FIFO_FULL};

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        addr_d    = BASE;
                        iss_rem_d = LEN;
                        pop_rem_d = LEN;
                        state_d   = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (credit) begin
                    csb_d     = 1'b0;
                    v1_d      = 1'b1;
                    a1_d      = addr_q;
                    addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                    iss_rem_d = iss_rem_q - LEN_W'(1);
                    if (iss_rem_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && pop) begin
            pop_rem_d = pop_rem_q - LEN_W'(1);
            if (pop_rem_q == LEN_W'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            a1_q      <= '0;
            iss_rem_q <= '0;
            pop_rem_q <= '0;
            csb_q     <= 1'b1;
            done_q    <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            a1_q      <= a1_d;
            iss_rem_q <= iss_rem_d;
            pop_rem_q <= pop_rem_d;
            csb_q     <= csb_d;
            done_q    <= done_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge CE) begin
        if (push) mem_q[wr_ptr_q] <= O1;
    end

    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign A1      = a1_q;
    assign CSB1    = csb_q;
    assign OEB1    = 1'b0;
    assign M_VALID = (cnt_q != '0);
    assign M_DATA  = M_VALID ? mem_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge CE) disable iff (!RSTB)
        !(push && (cnt_q == FIFO_FULL) && !pop)
    );
`endif
endmodule

// File: tb/tb_sram_rd_stream.sv
// Bench for sram_rd_stream: SRAM macro model, transaction-level
// stream model with per-cycle compare, and directed scenarios.
module tb_sram_rd_stream;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1296;
    localparam int LEN_W  = 12;
    localparam int FD     = 4;

    logic              CE = 1'b0;
    logic              RSTB;
    logic              START;
    logic [ADDR_W-1:0] BASE;
    logic [LEN_W-1:0]  LEN;
    logic              BUSY, DONE, CSB1, OEB1, M_VALID;
    logic [ADDR_W-1:0] A1;
    logic [DATA_W-1:0] O1;
    logic [DATA_W-1:0] M_DATA;
    logic              M_READY;

    sram_rd_stream dut (
        .CE(CE), .RSTB(RSTB), .START(START), .BASE(BASE), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .A1(A1), .CSB1(CSB1), .OEB1(OEB1),
        .O1(O1), .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY)
    );

    always #5 CE = ~CE;

    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        O1 = '0;
    end
    always @(posedge CE) if (!CSB1) O1 <= mem[A1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level model state
    int exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    bit busy_exp, done_exp;
    int iss_total, pops, t1, t2, xfer_pops, cur_len;
    // capture for scenario-level literal checks
    int got_addr[$];
    logic [DATA_W-1:0] got_data[$];
    int pop_cyc[$];
    int done_cnt, csb_cnt, first_csb, first_val, cyc;

    always @(negedge CE) begin
        bit done_nx, busy_cur;
        cyc++;
        if (!RSTB) begin
            exp_addr.delete();
            exp_data.delete();
            busy_exp = 0; done_exp = 0;
            iss_total = 0; pops = 0; t1 = 0; t2 = 0;
            xfer_pops = 0; cur_len = 0;
        end else begin
            busy_cur = busy_exp;
            chk("busy", BUSY, busy_exp);
            chk("done", DONE, done_exp);
            chk("oeb1", OEB1, 0);
            if (DONE) done_cnt++;
            if (!CSB1) begin
                csb_cnt++;
                iss_total++;
                if (first_csb < 0) first_csb = cyc;
                got_addr.push_back(int'(A1));
                if (exp_addr.size() == 0) chk("spurious_read", 1, 0);
                else chk("a1", A1, exp_addr.pop_front());
            end
            chk("credit", (iss_total - pops) <= FD, 1);
            chk("m_valid", M_VALID, (t2 - pops) > 0);
            if (M_VALID && first_val < 0) first_val = cyc;
            done_nx = 0;
            if (M_VALID && M_READY) begin
                got_data.push_back(M_DATA);
                pop_cyc.push_back(cyc);
                if (exp_data.size() == 0) chk("extra_word", 1, 0);
                else chk("m_data", M_DATA, exp_data.pop_front());
                pops++;
                xfer_pops++;
                if (xfer_pops == cur_len) begin
                    done_nx = 1;
                    busy_exp = 0;
                end
            end
            if (START && !busy_cur) begin
                if (LEN == 0) done_nx = 1;
                else begin
                    cur_len = int'(LEN);
                    xfer_pops = 0;
                    busy_exp = 1;
                    for (int i = 0; i < cur_len; i++) begin
                        exp_addr.push_back((int'(BASE) + i) % DEPTH);
                        exp_data.push_back(mem[(int'(BASE) + i) % DEPTH]);
                    end
                end
            end
            t2 = t1;
            t1 = iss_total;
            done_exp = done_nx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CE);
        #1;
    endtask

    task automatic clr();
        got_addr.delete();
        got_data.delete();
        pop_cyc.delete();
        done_cnt = 0; csb_cnt = 0; first_csb = -1; first_val = -1;
    endtask

    task automatic run(input int base, input int len);
        START = 1'b1;
        BASE  = ADDR_W'(base);
        LEN   = LEN_W'(len);
        tick(1);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            if (rnd) M_READY = ($urandom_range(0, 99) < 30);
            tick(1);
        end
        chk("done_timeout", done_cnt != d0, 1);
        M_READY = 1'b1;
    endtask

    task automatic chk_seq(input string name, input int first, input int n);
        chk({name, "_len"}, got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++)
            chk(name, got_data[i], DATA_W'((first + i) % DEPTH));
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_csb1"}, CSB1, 1);
        chk({name, "_a1"}, A1, 0);
        chk({name, "_oeb1"}, OEB1, 0);
        chk({name, "_busy"}, BUSY, 0);
        chk({name, "_done"}, DONE, 0);
        chk({name, "_mvalid"}, M_VALID, 0);
        chk({name, "_mdata"}, M_DATA, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        RSTB = 1'b0; START = 1'b0; BASE = '0; LEN = '0; M_READY = 1'b0;
        clr();
        tick(2);
        chk_reset_outs("reset");
        RSTB = 1'b1;
        tick(1);

        // streaming 10..17 at full rate
        M_READY = 1'b1;
        clr();
        run(10, 8);
        wait_done(100, 0);
        tick(3);
        chk_seq("stream", 10, 8);
        chk("stream_lat", first_val - first_csb, 2);
        if (pop_cyc.size() == 8) chk("stream_rate", pop_cyc[7] - pop_cyc[0], 7);
        chk("stream_done_cnt", done_cnt, 1);

        // address wrap at DEPTH-1
        clr();
        run(1292, 6);
        wait_done(100, 0);
        tick(2);
        chk("wrap_n", got_addr.size(), 6);
        if (got_addr.size() == 6) begin
            chk("wrap_a0", got_addr[0], 1292);
            chk("wrap_a3", got_addr[3], 1295);
            chk("wrap_a4", got_addr[4], 0);
            chk("wrap_a5", got_addr[5], 1);
        end
        chk_seq("wrap", 1292, 6);

        // random backpressure
        clr();
        run(0, 20);
        wait_done(600, 1);
        tick(3);
        chk_seq("bp", 0, 20);
        chk("bp_done_cnt", done_cnt, 1);

        // zero length
        clr();
        run(5, 0);
        tick(3);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_csb_cnt", csb_cnt, 0);

        // START during a transfer is ignored
        clr();
        run(0, 16);
        tick(3);
        run(200, 5);
        wait_done(200, 0);
        tick(10);
        chk_seq("ign", 0, 16);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_csb_cnt", csb_cnt, 16);

        // asynchronous reset mid-transfer
        clr();
        run(0, 32);
        for (int i = 0; i < 100 && got_data.size() < 5; i++) tick(1);
        chk("rst_words_seen", got_data.size() >= 5, 1);
        #2;
        RSTB = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        @(posedge CE);
        #1;
        RSTB = 1'b1;
        chk("rst_no_done", done_cnt, 0);
        clr();
        run(100, 4);
        wait_done(100, 0);
        tick(2);
        chk_seq("post_rst", 100, 4);
        chk("post_rst_done_cnt", done_cnt, 1);

        // full FIFO stall
        clr();
        M_READY = 1'b0;
        run(0, 10);
        tick(20);
        chk("stall_csb_cnt", csb_cnt, 4);
        chk("stall_no_pop", got_data.size(), 0);
        M_READY = 1'b1;
        wait_done(100, 0);
        tick(2);
        chk_seq("stall", 0, 10);
        chk("stall_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
